// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory request/response bus between the fetch queue (master) and imem (slave).
interface fetch_queue_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        tag;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rtag;

  modport master (
    output req, addr, tag,
    input  gnt, rvalid, rdata, rtag
  );

  modport slave (
    input  req, addr, tag,
    output gnt, rvalid, rdata, rtag
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests and buffers responses for F/D.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStallD,
  input  logic                iPCSrcE,
  input  logic [31:0]         iPCTargetE,
  fetch_queue_unit_if.master  imem,
  output logic                oValidF,
  output logic [31:0]         oRDF,
  output logic [31:0]         oPCF,
  output logic [31:0]         oPCPlus4F
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;

  logic [31:0]   pc_q;
  logic          epoch_q;
  logic          started_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] qcnt_q;
  ptr_t          q_wptr_q, q_rptr_q;
  ptr_t          s_wptr_q, s_rptr_q;
  logic [31:0]   q_instr_q [DEPTH];
  logic [31:0]   q_pc_q    [DEPTH];
  logic [31:0]   s_pc_q    [DEPTH];

  logic [CW:0]   inflight;
  logic          grant;
  logic          resp_ok;
  logic          head_valid;
  logic          bypass;
  logic          consume;
  logic          push;
  logic          pop;
  logic [31:0]   resp_pc;

  // Queue slots plus in-flight requests never exceed DEPTH, so a push can never overflow.
  assign inflight   = {1'b0, qcnt_q} + {1'b0, outst_q};
  assign imem.req   = started_q && !iPCSrcE && (inflight < (CW+1)'(DEPTH));
  assign imem.addr  = pc_q;
  assign imem.tag   = epoch_q;
  assign grant      = imem.req && imem.gnt;
  assign resp_ok    = imem.rvalid && (imem.rtag == epoch_q) && !iPCSrcE;
  assign head_valid = (qcnt_q != '0);
  assign resp_pc    = s_pc_q[s_rptr_q];

`ifdef FETCH_BYPASS_EN
  assign bypass  = !head_valid && resp_ok;
  assign consume = bypass && !iStallD;
`else
  assign bypass  = 1'b0;
  assign consume = 1'b0;
`endif

  assign push = resp_ok && !consume;
  assign pop  = head_valid && !iStallD && !iPCSrcE;

  always_comb begin
    oValidF = head_valid;
    oPCF    = q_pc_q[q_rptr_q];
    oRDF    = head_valid ? q_instr_q[q_rptr_q] : NOP;
    if (bypass) begin
      oValidF = 1'b1;
      oPCF    = resp_pc;
      oRDF    = imem.rdata;
    end
    oPCPlus4F = oPCF + 32'd4;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pc_q      <= RESET_PC;
      epoch_q   <= 1'b0;
      started_q <= 1'b0;
      outst_q   <= '0;
      qcnt_q    <= '0;
      q_wptr_q  <= '0;
      q_rptr_q  <= '0;
      s_wptr_q  <= '0;
      s_rptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
        s_pc_q[i]    <= '0;
      end
    end else begin
      started_q <= 1'b1;
      // Stale responses still retire an outstanding slot.
      outst_q   <= outst_q + CW'(grant) - CW'(imem.rvalid);
      if (iPCSrcE) begin
        pc_q     <= {iPCTargetE[31:2], 2'b00};
        epoch_q  <= ~epoch_q;
        qcnt_q   <= '0;
        q_wptr_q <= '0;
        q_rptr_q <= '0;
        s_wptr_q <= '0;
        s_rptr_q <= '0;
      end else begin
        if (grant) begin
          pc_q             <= pc_q + 32'd4;
          s_pc_q[s_wptr_q] <= pc_q;
          s_wptr_q         <= s_wptr_q + ptr_t'(1);
        end
        // Stale responses belong to requests already flushed from the side FIFO.
        if (resp_ok) begin
          s_rptr_q <= s_rptr_q + ptr_t'(1);
        end
        if (push) begin
          q_instr_q[q_wptr_q] <= imem.rdata;
          q_pc_q[q_wptr_q]    <= resp_pc;
          q_wptr_q            <= q_wptr_q + ptr_t'(1);
        end
        if (pop) begin
          q_rptr_q <= q_rptr_q + ptr_t'(1);
        end
        qcnt_q <= qcnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  a_no_push_full : assert property (@(posedge iClk) disable iff (!iRstN)
    push |-> (qcnt_q < CW'(DEPTH)));
  a_no_orphan_resp : assert property (@(posedge iClk) disable iff (!iRstN)
    imem.rvalid |-> (outst_q != '0));

endmodule
